// File: rtl/argmax_stream.sv
// argmax_stream: streaming argmax over score vectors with valid/ready handshake.
// One score per accepted beat. Tracks the running maximum and its index, and
// posts {index, value} into a one-deep output register on the vector's last beat.
module argmax_stream #(
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 8,
  parameter bit SIGNED      = 1'b0,
  parameter bit TIE_LAST    = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [INDEX_WIDTH-1:0] cfg_length,
  input  logic                   abort,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DATA_WIDTH-1:0]  in_value,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [INDEX_WIDTH-1:0] out_index,
  output logic [DATA_WIDTH-1:0]  out_value,
  output logic                   busy
);

  logic [INDEX_WIDTH-1:0] elem_cnt, len_q, len_eff, len_cur, nxt_idx;
  logic [INDEX_WIDTH-1:0] best_idx;
  logic [DATA_WIDTH-1:0]  best, nxt_best;
  logic                   accept, first, last, gt, eq, win;

  // Handshake, compare and next-winner selection
  always_comb begin
    in_ready = (~out_valid | out_ready) & ~abort;
    accept   = in_valid & in_ready;
    first    = (elem_cnt == '0);
    // A length of 0 is treated as 1
    len_eff  = (cfg_length == '0) ? {{(INDEX_WIDTH-1){1'b0}}, 1'b1} : cfg_length;
    // The first beat uses the live config; later beats use the latched length
    len_cur  = first ? len_eff : len_q;
    last     = (elem_cnt == len_cur - 1'b1);
    if (SIGNED) gt = $signed(in_value) > $signed(best);
    else        gt = in_value > best;
    eq       = (in_value == best);
    // The first beat always loads; afterwards the tie policy picks >= or >
    win      = first | gt | (TIE_LAST & eq);
    nxt_best = win ? in_value : best;
    nxt_idx  = win ? elem_cnt : best_idx;
  end

  // Running maximum, element counter and latched vector length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      elem_cnt <= '0;
      best     <= '0;
      best_idx <= '0;
      len_q    <= '0;
    end else if (abort) begin
      elem_cnt <= '0;
      best     <= '0;
      best_idx <= '0;
    end else if (accept) begin
      if (first) len_q <= len_eff;
      best     <= nxt_best;
      best_idx <= nxt_idx;
      elem_cnt <= last ? '0 : elem_cnt + 1'b1;
    end
  end

  // One-deep result register; a new result overwrites in place
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_index <= '0;
      out_value <= '0;
    end else if (accept && last) begin
      out_valid <= 1'b1;
      out_index <= nxt_idx;
      out_value <= nxt_best;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign busy = (elem_cnt != '0);

endmodule

// File: tb/tb_argmax_stream.sv
// Bench for argmax_stream: three instances (default, earlier-wins ties, signed)
// share one stimulus; table-driven vectors plus hand-written corner sequences.
module tb_argmax_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] cfg_length;
  logic       abort, in_valid, out_ready;
  logic [7:0] in_value;
  logic [2:0] ov, bz, ir;
  logic [7:0] oi [3];
  logic [7:0] oval [3];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  argmax_stream #(.SIGNED(1'b0), .TIE_LAST(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_length(cfg_length), .abort(abort),
    .in_valid(in_valid), .in_ready(ir[0]), .in_value(in_value),
    .out_valid(ov[0]), .out_ready(out_ready), .out_index(oi[0]),
    .out_value(oval[0]), .busy(bz[0]));

  argmax_stream #(.SIGNED(1'b0), .TIE_LAST(1'b0)) u_tie0 (
    .clk(clk), .rst_n(rst_n), .cfg_length(cfg_length), .abort(abort),
    .in_valid(in_valid), .in_ready(ir[1]), .in_value(in_value),
    .out_valid(ov[1]), .out_ready(out_ready), .out_index(oi[1]),
    .out_value(oval[1]), .busy(bz[1]));

  argmax_stream #(.SIGNED(1'b1), .TIE_LAST(1'b1)) u_sgn (
    .clk(clk), .rst_n(rst_n), .cfg_length(cfg_length), .abort(abort),
    .in_valid(in_valid), .in_ready(ir[2]), .in_value(in_value),
    .out_valid(ov[2]), .out_ready(out_ready), .out_index(oi[2]),
    .out_value(oval[2]), .busy(bz[2]));

  typedef struct {
    int             len;
    int             n;
    logic [3:0][7:0] v;   // v[0] is the first beat
    int             iu;   // expected index, unsigned, later wins ties
    int             it0;  // expected index, unsigned, earlier wins ties
    int             is;   // expected index, signed, later wins ties
    logic [7:0]     vu;   // expected value, unsigned instances
    logic [7:0]     vs;   // expected value, signed instance
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] v);
    in_valid = 1'b1;
    in_value = v;
    tick();
  endtask

  initial begin
    tbl[0] = '{4, 4, {8'h05, 8'h02, 8'h09, 8'h03}, 1, 1, 1, 8'h09, 8'h09};
    tbl[1] = '{4, 4, {8'h07, 8'h01, 8'h07, 8'h07}, 3, 0, 3, 8'h07, 8'h07};
    tbl[2] = '{3, 3, {8'h00, 8'hFF, 8'h80, 8'hFE}, 2, 2, 2, 8'hFF, 8'hFF};
    tbl[3] = '{0, 1, {8'h00, 8'h00, 8'h00, 8'h42}, 0, 0, 0, 8'h42, 8'h42};
    tbl[4] = '{1, 1, {8'h00, 8'h00, 8'h00, 8'h80}, 0, 0, 0, 8'h80, 8'h80};
    tbl[5] = '{2, 2, {8'h00, 8'h00, 8'h7F, 8'h80}, 0, 0, 1, 8'h80, 8'h7F};
    tbl[6] = '{4, 4, {8'h00, 8'h00, 8'h00, 8'h00}, 3, 0, 3, 8'h00, 8'h00};

    rst_n = 1'b0; cfg_length = 8'd4; abort = 1'b0;
    in_valid = 1'b0; in_value = 8'h00; out_ready = 1'b1;
    #2;
    chk("rst_out_valid", ov[0], 1'b0);
    chk("rst_out_index", oi[0], 8'h00);
    chk("rst_out_value", oval[0], 8'h00);
    chk("rst_busy", bz[0], 1'b0);
    chk("rst_in_ready", ir[0], 1'b1);
    tick();
    rst_n = 1'b1;
    tick();

    // Table-driven vectors, out_ready held high
    for (int t = 0; t < 7; t++) begin
      cfg_length = 8'(tbl[t].len);
      for (int i = 0; i < tbl[t].n; i++) begin
        beat(tbl[t].v[i]);
        if (i < tbl[t].n - 1) begin
          chk($sformatf("v%0d_mid_valid", t), ov[0], 1'b0);
          chk($sformatf("v%0d_mid_busy", t), bz[0], 1'b1);
        end
      end
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", t), {ov[2], ov[1], ov[0]}, 3'b111);
      chk($sformatf("v%0d_busy", t), bz[0], 1'b0);
      chk($sformatf("v%0d_idx_u", t), oi[0], tbl[t].iu);
      chk($sformatf("v%0d_idx_t0", t), oi[1], tbl[t].it0);
      chk($sformatf("v%0d_idx_s", t), oi[2], tbl[t].is);
      chk($sformatf("v%0d_val_u", t), oval[0], tbl[t].vu);
      chk($sformatf("v%0d_val_t0", t), oval[1], tbl[t].vu);
      chk($sformatf("v%0d_val_s", t), oval[2], tbl[t].vs);
    end
    tick();
    chk("drain_valid", ov[0], 1'b0);

    // Backpressure: {1,4} then {6,2} with out_ready low
    cfg_length = 8'd2; out_ready = 1'b0;
    beat(8'd1);
    beat(8'd4);
    chk("bp_r1_valid", ov[0], 1'b1);
    chk("bp_in_ready_low", ir[0], 1'b0);
    in_value = 8'd6;
    tick();
    tick();
    chk("bp_hold_valid", ov[0], 1'b1);
    chk("bp_hold_index", oi[0], 8'd1);
    chk("bp_hold_value", oval[0], 8'd4);
    chk("bp_hold_busy", bz[0], 1'b0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_high", ir[0], 1'b1);
    tick();
    chk("bp_r1_consumed", ov[0], 1'b0);
    chk("bp_busy", bz[0], 1'b1);
    beat(8'd2);
    in_valid = 1'b0;
    chk("bp_r2_valid", ov[0], 1'b1);
    chk("bp_r2_index", oi[0], 8'd0);
    chk("bp_r2_value", oval[0], 8'd6);
    tick();

    // Abort mid-vector
    cfg_length = 8'd4;
    beat(8'd5);
    beat(8'd8);
    abort = 1'b1;
    in_value = 8'd99;
    #1;
    chk("ab_in_ready", ir[0], 1'b0);
    tick();
    abort = 1'b0;
    chk("ab_busy", bz[0], 1'b0);
    chk("ab_valid", ov[0], 1'b0);
    beat(8'd2);
    beat(8'd1);
    beat(8'd3);
    beat(8'd0);
    in_valid = 1'b0;
    chk("ab_res_valid", ov[0], 1'b1);
    chk("ab_res_index", oi[0], 8'd2);
    chk("ab_res_value", oval[0], 8'd3);
    tick();

    // cfg_length change mid-vector is ignored
    cfg_length = 8'd3;
    beat(8'd1);
    cfg_length = 8'd1;
    beat(8'd2);
    chk("cfg_mid_valid", ov[0], 1'b0);
    beat(8'd3);
    in_valid = 1'b0;
    chk("cfg_valid", ov[0], 1'b1);
    chk("cfg_index", oi[0], 8'd2);
    chk("cfg_value", oval[0], 8'd3);

    // Async reset with a held result, then mid-vector
    out_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("arst_held_valid", ov[0], 1'b0);
    chk("arst_held_index", oi[0], 8'd0);
    chk("arst_held_value", oval[0], 8'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    cfg_length = 8'd4;
    beat(8'h42);
    beat(8'h10);
    in_valid = 1'b0;
    chk("arst_pre_busy", bz[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("arst_mid_busy", bz[0], 1'b0);
    chk("arst_mid_valid", ov[0], 1'b0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
